// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32 datapath.
// Sequence: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with HALT as an
// absorbing error/stop state. Memory handshakes are bounded by a wait counter.
// Optional feature macro: ECALL_HALT_EN (ECALL opcode halts cleanly instead of
// being reported as illegal).
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUop,
  output logic [2:0]  RW_type,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal,
  output logic        timeout_err,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [6:0]       ir_opcode;
  logic [2:0]       ir_func3;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q, timeout_q, halted_q;
  logic             set_illegal, set_timeout, set_halted;

  // Only opcode and func3 are kept; the datapath owns the rest of the word.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  // Instruction class decode of the latched IR.
  logic is_load, is_store, is_rtype, is_itype, is_upper;
  logic is_jal, is_jalr, is_branch, is_ecall, is_known;
  assign is_load   = (ir_opcode == OP_LOAD);
  assign is_store  = (ir_opcode == OP_STORE);
  assign is_rtype  = (ir_opcode == OP_RTYPE);
  assign is_itype  = (ir_opcode == OP_ITYPE);
  assign is_upper  = (ir_opcode == OP_LUI) || (ir_opcode == OP_AUIPC);
  assign is_jal    = (ir_opcode == OP_JAL);
  assign is_jalr   = (ir_opcode == OP_JALR);
  assign is_branch = (ir_opcode == OP_BRANCH);
  assign is_ecall  = (ir_opcode == OP_SYSTEM);
  assign is_known  = is_load | is_store | is_rtype | is_itype | is_upper |
                     is_jal | is_jalr | is_branch;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic, including the causes for entering HALT.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    set_halted  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // Ready in the cycle the counter hits the limit still wins.
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_cnt == TMO_CNT) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
`ifdef ECALL_HALT_EN
        if (is_ecall) begin
          state_d    = S_HALT;
          set_halted = 1'b1;
        end else
`endif
        if (!is_known) begin
          state_d     = S_HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (wait_cnt == TMO_CNT) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Handshake wait counter: restarts on each entry to a waiting state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state_d != state_q) &&
                 ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_cnt <= '0;
    end else if (((state_q == S_FETCH) && !imem_ready) ||
                 ((state_q == S_MEM) && !dmem_ready)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Instruction register: opcode and func3 captured on the fetch handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_opcode <= '0;
      ir_func3  <= '0;
    end else if ((state_q == S_FETCH) && imem_ready) begin
      ir_opcode <= instr[6:0];
      ir_func3  <= instr[14:12];
    end
  end

  // Sticky status flags, set on the transition into HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
      if (set_halted)  halted_q  <= 1'b1;
    end
  end

  // Output decode; everything is forced low while rst is held.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    ALUop    = 2'b00;
    retire   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        S_EXEC: begin
          if (is_rtype)       ALUop = 2'b10;
          else if (is_itype)  ALUop = 2'b01;
          else if (is_branch) ALUop = 2'b11;
          ALUSrc = is_load | is_store | is_itype | is_jalr;
          if (is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemRead  = is_load;
          MemWrite = is_store;
          if (dmem_ready && is_store) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = is_load;
          pc_write = 1'b1;
          pc_src   = is_jal | is_jalr;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign RW_type     = ir_func3;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;
  assign halted      = halted_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles on any memory handshake; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the wait counter; SHALL satisfy 2^CNT_W > MEM_TIMEOUT.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr  in  32  instruction word from instruction memory, valid when imem_ready=1.
REQ-006 imem_ready  in  1  instruction memory completion strobe.
REQ-007 dmem_ready  in  1  data memory completion strobe.
REQ-008 branch_taken  in  1  comparator result for the latched branch, valid in EXEC.
REQ-009 imem_req, dmem_req  out  1 each  memory request, held high until the matching ready.
REQ-010 ir_write, pc_write, pc_src  out  1 each  IR load, PC load, PC select (0 = pc+4, 1 = target).
REQ-011 MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite  out  1 each  datapath controls.
REQ-012 ALUop  out  2  00 add, 01 I-type, 10 R-type, 11 branch.
REQ-013 RW_type  out  3  func3 of the latched instruction.
REQ-014 state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-015 retire, illegal, timeout_err, halted  out  1 each  status outputs.

Function
REQ-016 Opcode and func3 SHALL be latched into an internal IR when FETCH sees imem_ready=1; ir_write pulses high in that cycle.
REQ-017 FETCH: imem_req=1; stays in FETCH until imem_ready, then moves to DECODE.
REQ-018 DECODE: one cycle. Unknown opcode -> HALT with illegal=1; otherwise -> EXEC.
REQ-019 EXEC: one cycle. ALUop and ALUSrc are driven from the IR (ALUSrc for load, store, I-type, jalr). Next state: load/store -> MEM; R/I/U/jal/jalr -> WB; branch -> FETCH.
REQ-020 Branch in EXEC: pc_write=1, pc_src=branch_taken, retire=1 pulse.
REQ-021 MEM: dmem_req=1, MemRead=load, MemWrite=store; stays in MEM until dmem_ready. Store then goes to FETCH with pc_write=1, pc_src=0 and retire=1; load goes to WB.
REQ-022 WB: one cycle; RegWrite=1, MemtoReg=load, pc_write=1, retire=1. pc_src=1 for jal/jalr, otherwise 0. Next state is FETCH.
REQ-023 All datapath controls SHALL be 0 outside the states named above; RW_type is always the IR func3.
REQ-024 Wait counter: cleared on entry to FETCH or MEM; increments each cycle the ready input is low. Reaching MEM_TIMEOUT with ready still low -> HALT with timeout_err=1.
REQ-025 Ready asserted in the same cycle the counter reaches MEM_TIMEOUT: ready wins and no error is raised.
REQ-026 HALT: absorbing; all requests and controls are 0; status flags are held; only rst exits.
REQ-027 Latency: ALU instruction 4 cycles, load 5, store 4, branch 3, with zero-wait memories.

Reset
REQ-028 rst=1 at any edge, including mid-handshake, SHALL force:
- state=FETCH;
- IR=0;
- wait counter=0;
- all outputs and flags=0.
REQ-029 imem_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-030 Macro ECALL_HALT_EN:
- Defined: opcode 1110011 in DECODE -> HALT with halted=1 and illegal=0.
- Undefined: opcode 1110011 is illegal (illegal=1); halted stays 0 permanently.

Verification
REQ-031 add x1,x2,x3 (0x003100B3) with zero-wait memories -> state sequence 0,1,2,4,0; ALUop=10 in EXEC; RegWrite=1 and retire=1 in WB.
REQ-032 lw (0x0000A083) with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles; MemRead=1 in MEM; MemtoReg=1 in WB; RW_type=010.
REQ-033 beq (func3 000) with branch_taken=1 -> pc_write=1, pc_src=1, retire=1 in EXEC; the next cycle is FETCH.
REQ-034 imem_ready held low with MEM_TIMEOUT=4 -> HALT after 4 wait cycles with timeout_err=1; a subsequent rst returns state=0.
REQ-035 Opcode 1110011: with ECALL_HALT_EN -> halted=1; without it -> illegal=1. Opcode 0000000 -> illegal=1 in either build.
